// File: rtl/byte_pack_if.sv
// Handshake bundle between the counter-bank sources, the packing scheduler and the output FIFO.
interface byte_pack_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    localparam int WORD_W = DATA_W * LANES;
    localparam int PTR_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(LANES + 1);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    flush;
    logic [WORD_W-1:0]       word_out;
    logic [CNT_W-1:0]        word_bytes;
    logic [LANES*PTR_W-1:0]  word_src;
    logic                    word_valid;
    logic                    word_ready;

    modport master (
        output req_valid, req_data, flush, word_ready,
        input  req_ready, word_out, word_bytes, word_src, word_valid
    );

    modport slave (
        input  req_valid, req_data, flush, word_ready,
        output req_ready, word_out, word_bytes, word_src, word_valid
    );
endinterface

// File: rtl/byte_pack_scheduler.sv
// Round-robin arbiter that packs one granted source byte per cycle into a shared
// word register and hands the full or flushed word to the FIFO via valid/ready.
module byte_pack_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input logic        clk,
    input logic        rst,
    byte_pack_if.slave bus
);
    localparam int WORD_W = DATA_W * LANES;
    localparam int PTR_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(LANES + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr, rr_nxt;
    logic [CNT_W-1:0]       fill_cnt, fill_nxt;
    logic [WORD_W-1:0]      word_q, word_nxt;
    logic [LANES*PTR_W-1:0] src_q, src_nxt;

    logic                   gnt_found;
    logic [PTR_W-1:0]       gnt_idx;
    logic [DATA_W-1:0]      gnt_data;
    logic                   accept;

    function automatic logic [PTR_W-1:0] rr_inc(input logic [PTR_W-1:0] g);
        if (g == PTR_W'(N_REQ - 1)) return '0;
        return g + 1'b1;
    endfunction

    // Round-robin search beginning at rr_ptr; first valid source wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = PTR_W'(idx);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign accept        = (state == FILL) && gnt_found && !rst;
    assign gnt_data      = bus.req_data[gnt_idx*DATA_W +: DATA_W];
    assign bus.req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        fill_nxt  = fill_cnt;
        word_nxt  = word_q;
        src_nxt   = src_q;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (fill_cnt == CNT_W'(k)) begin
                            word_nxt[k*DATA_W +: DATA_W] = gnt_data;
                            src_nxt[k*PTR_W +: PTR_W]    = gnt_idx;
                        end
                    end
                    fill_nxt = fill_cnt + 1'b1;
                    rr_nxt   = rr_inc(gnt_idx);
                end
                // An empty word with nothing arriving gives flush nothing to close.
                if (accept && fill_cnt == CNT_W'(LANES - 1))
                    state_nxt = HOLD;
                else if (bus.flush && (fill_cnt != '0 || accept))
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.word_ready) begin
                    fill_nxt  = '0;
                    word_nxt  = '0;
                    src_nxt   = '0;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            rr_ptr   <= '0;
            fill_cnt <= '0;
            word_q   <= '0;
            src_q    <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            fill_cnt <= fill_nxt;
            word_q   <= word_nxt;
            src_q    <= src_nxt;
        end
    end

    // The lane count doubles as the byte count of the presented word.
    assign bus.word_out   = word_q;
    assign bus.word_src   = src_q;
    assign bus.word_bytes = fill_cnt;
    assign bus.word_valid = (state == HOLD);
endmodule
